// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO framer.
//   state_e         : framer FSM states (IDLE, DATA, CSUM)
//   FIFO_WIDTH_DEF  : default width of FIFO read data and stream words
//   FRAME_LEN_DEF   : default number of data words per frame
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CSUM = 2'd2
  } state_e;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FRAME_LEN_DEF  = 8;

endpackage

// File: rtl/fifo_framer_skid_buf2.sv
// skid_buf2: two-entry in-order staging buffer between the FIFO read port
// and the output stream.
// Ports:
//   clk_rd  : clock (rising edge)
//   rst     : asynchronous active-high reset, empties the buffer
//   push_i  : write data_i this cycle
//   data_i  : word to store
//   pop_i   : drop the head word this cycle (only when count_o != 0)
//   head_o  : oldest stored word
//   count_o : number of stored words (0..2)
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
  input  logic                  clk_rd,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [FIFO_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [FIFO_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [FIFO_WIDTH-1:0] e0_q, e0_d;
  logic [FIFO_WIDTH-1:0] e1_q, e1_d;
  logic [1:0]            cnt_q, cnt_d;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = data_i;
        else               e1_d = data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = data_i;
        end else begin
          e0_d = e1_q;
          e1_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fifo_framer.sv
// fifo_framer: reads words from a FIFO and emits frames of FRAME_LEN data
// words followed by one checksum word (sum of the data words, carries dropped).
// Ports:
//   clk_rd     : only clock, rising edge
//   rst        : asynchronous active-high reset
//   empty      : FIFO empty flag
//   underflow  : FIFO underflow flag (sets err)
//   data_out   : FIFO read data, valid the cycle after rd_en
//   rd_en      : FIFO read request
//   out_data   : stream word
//   out_valid  : stream word valid
//   out_last   : marks the checksum word ending a frame
//   out_ready  : downstream accept
//   frame_cnt  : completed frames, wraps at 0xFFFF
//   err        : sticky protocol error, cleared only by rst
module fifo_framer
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                  clk_rd,
  input  logic                  rst,
  input  logic                  empty,
  input  logic                  underflow,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [15:0]           frame_cnt,
  output logic                  err
);

  localparam int            CW         = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LEN_C      = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX_C = CW'(FRAME_LEN - 1);

  state_e                state_q, state_d;
  logic                  rd_pend_q;
  logic [CW-1:0]         req_cnt_q, req_cnt_d;
  logic [CW-1:0]         acc_cnt_q, acc_cnt_d;
  logic [FIFO_WIDTH-1:0] csum_q, csum_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  err_q, err_d;

  logic [FIFO_WIDTH-1:0] sk_head;
  logic [1:0]            sk_cnt;
  logic                  data_fire;
  logic                  csum_fire;
  logic [2:0]            occ_next;

  // Stage boundary: FIFO read data lands in the skid buffer one cycle after rd_en.
  skid_buf2 #(.FIFO_WIDTH(FIFO_WIDTH)) u_skid (
    .clk_rd  (clk_rd),
    .rst     (rst),
    .push_i  (rd_pend_q),
    .data_i  (data_out),
    .pop_i   (data_fire),
    .head_o  (sk_head),
    .count_o (sk_cnt)
  );

  // Stage boundary: output stream presented from the skid head or the checksum register.
  assign out_valid = (state_q == CSUM) || ((state_q == DATA) && (sk_cnt != 2'd0));
  assign out_last  = (state_q == CSUM);
  assign out_data  = (state_q == CSUM) ? csum_q : sk_head;
  assign data_fire = (state_q == DATA) && out_valid && out_ready;
  assign csum_fire = (state_q == CSUM) && out_ready;

  // Occupancy counts the word popped this cycle as already gone, so a
  // continuously ready sink sees one word per cycle with no bubbles.
  assign occ_next = {1'b0, sk_cnt} - {2'b00, data_fire} + {2'b00, rd_pend_q};
  assign rd_en    = (state_q == DATA) && !empty && (occ_next < 3'd2) &&
                    (req_cnt_q < LEN_C);

  assign frame_cnt = frame_cnt_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    req_cnt_d   = req_cnt_q + CW'(rd_en);
    acc_cnt_d   = acc_cnt_q + CW'(data_fire);
    csum_d      = data_fire ? (csum_q + sk_head) : csum_q;
    frame_cnt_d = frame_cnt_q;
    // Second term guards against the checksum word ever leaving without out_last.
    err_d       = err_q || underflow ||
                  ((state_q == CSUM) && out_valid && !out_last);
    case (state_q)
      IDLE: if (!empty) state_d = DATA;
      DATA: if (data_fire && (acc_cnt_q == LAST_IDX_C)) state_d = CSUM;
      CSUM: begin
        if (csum_fire) begin
          state_d     = empty ? IDLE : DATA;
          req_cnt_d   = '0;
          acc_cnt_d   = '0;
          csum_d      = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A read in flight when reset releases is dropped because rd_pend_q clears.
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_pend_q   <= 1'b0;
      req_cnt_q   <= '0;
      acc_cnt_q   <= '0;
      csum_q      <= '0;
      frame_cnt_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_en;
      req_cnt_q   <= req_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      csum_q      <= csum_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule
